// File: rtl/banco_registradores_param_if.sv
// Port bundle for the parametrised register bank: one write port, two
// enabled read ports, and the clear-sweep control.
interface banco_registradores_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wrEn;
    logic [ADDR_W-1:0] addWr;
    logic [DATA_W-1:0] dadoWr;
    logic              rdEn1;
    logic [ADDR_W-1:0] addR1;
    logic [DATA_W-1:0] dadoR1;
    logic              rdEn2;
    logic [ADDR_W-1:0] addR2;
    logic [DATA_W-1:0] dadoR2;
    logic              clr;
    logic              busy;

    modport master (
        output wrEn, addWr, dadoWr, rdEn1, addR1, rdEn2, addR2, clr,
        input  dadoR1, dadoR2, busy
    );

    modport slave (
        input  wrEn, addWr, dadoWr, rdEn1, addR1, rdEn2, addR2, clr,
        output dadoR1, dadoR2, busy
    );
endinterface

// File: rtl/banco_registradores_param.sv
// Parametrised register bank: 2 registered read ports, 1 write port, optional
// write-to-read bypass, IDLE/CLEAR sweep. BANCO_ZERO_REG_EN hardwires entry 0 to 0.
module banco_registradores_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int INIT_BASE = 'hF0,
    parameter int BYPASS    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    banco_registradores_param_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
`ifdef BANCO_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd1, rd2;

    function automatic logic [DATA_W-1:0] init_val(input int i);
        if (ZERO_REG && i == 0) return '0;
        return DATA_W'(INIT_BASE + i);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The sweep borrows the single write port, so user writes are dropped in CLEAR.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we        = 1'b0;
        wa        = bus.addWr;
        wd        = bus.dadoWr;
        case (state)
            IDLE: begin
                we = bus.wrEn && !(ZERO_REG && bus.addWr == '0);
                if (bus.clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                we = 1'b1;
                wa = cnt;
                wd = init_val(int'(cnt));
                if (cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd1 = mem[bus.addR1];
        rd2 = mem[bus.addR2];
        if (BYPASS != 0 && we && wa == bus.addR1) rd1 = wd;
        if (BYPASS != 0 && we && wa == bus.addR2) rd2 = wd;
        if (ZERO_REG && bus.addR1 == '0) rd1 = '0;
        if (ZERO_REG && bus.addR2 == '0) rd2 = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.dadoR1 <= '0;
            bus.dadoR2 <= '0;
        end else begin
            if (bus.rdEn1) bus.dadoR1 <= rd1;
            if (bus.rdEn2) bus.dadoR2 <= rd2;
        end
    end

    assign bus.busy = (state == CLEAR);
endmodule
